// File: rtl/skin_width_arbiter.sv
`timescale 1ns/1ps
// skin_width_arbiter
// Round-robin sharing of one subtract/multiply/add width pipeline between the
// Cb and Cr width requesters. Results are unsigned (9,9) fixed point.
module skin_width_arbiter #(
    parameter logic [7:0]  K_L      = 8'd125,
    parameter logic [7:0]  K_H      = 8'd188,
    parameter logic [7:0]  Y_MIN    = 8'd16,
    parameter logic [7:0]  Y_MAX    = 8'd235,
    parameter logic [7:0]  WL_CB    = 8'd23,
    parameter logic [7:0]  WH_CB    = 8'd14,
    parameter logic [7:0]  W_CB     = 8'd47,
    parameter logic [7:0]  WL_CR    = 8'd20,
    parameter logic [7:0]  WH_CR    = 8'd10,
    parameter logic [7:0]  W_CR     = 8'd39,
    parameter logic [17:0] REV_L_CB = 18'h00041,
    parameter logic [17:0] REV_H_CB = 18'h00167,
    parameter logic [17:0] REV_L_CR = 18'h00058,
    parameter logic [17:0] REV_H_CR = 18'h00139
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cb_y_value,
    input  logic        cb_y_value_valid,
    output logic        cb_ready,
    input  logic [7:0]  cr_y_value,
    input  logic        cr_y_value_valid,
    output logic        cr_ready,
    output logic [17:0] width_cb_result,
    output logic        width_cb_result_valid,
    output logic [17:0] width_cr_result,
    output logic        width_cr_result_valid
);

    typedef enum logic [1:0] {
        REG_LOW  = 2'd0,
        REG_MID  = 2'd1,
        REG_HIGH = 2'd2
    } region_t;

    localparam logic TAG_CB = 1'b0;
    localparam logic TAG_CR = 1'b1;

    // Any bit at or above 2^18 means the (9,9) result cannot be represented.
    function automatic logic [17:0] sat_width(input logic [26:0] sum);
        if (sum[26:18] != 9'd0) begin
            return 18'h3FFFF;
        end
        return sum[17:0];
    endfunction

    // a - b, floored at zero.
    function automatic logic [7:0] clamp_sub(input logic [7:0] a, input logic [7:0] b);
        if (a < b) begin
            return 8'd0;
        end
        return a - b;
    endfunction

    logic        grant_cb;
    logic        grant_cr;
    logic        last_d, last_q;

    logic        vld_p0_d, vld_p0_q;
    logic        tag_p0_d, tag_p0_q;
    logic [7:0]  y_p0_d, y_p0_q;

    logic        vld_p1_d, vld_p1_q;
    logic        tag_p1_d, tag_p1_q;
    region_t     region_p1_d, region_p1_q;
    logic [7:0]  diff_p1_d, diff_p1_q;
    logic [17:0] rev_p1_d, rev_p1_q;
    logic [7:0]  off_p1_d, off_p1_q;

    logic        vld_p2_d, vld_p2_q;
    logic        tag_p2_d, tag_p2_q;
    region_t     region_p2_d, region_p2_q;
    logic [25:0] prod_p2_d, prod_p2_q;
    logic [7:0]  off_p2_d, off_p2_q;

    logic [26:0] sum_p2;
    logic [17:0] res_p2;

    logic [17:0] cb_res_d, cb_res_q;
    logic        cb_vld_d, cb_vld_q;
    logic [17:0] cr_res_d, cr_res_q;
    logic        cr_vld_d, cr_vld_q;

    // Arbitration: grant the requester that did not win last; ready is the grant.
    always_comb begin
        grant_cb = 1'b0;
        grant_cr = 1'b0;
        if (!rst) begin
            if (cb_y_value_valid && (!cr_y_value_valid || last_q == TAG_CR)) begin
                grant_cb = 1'b1;
            end else if (cr_y_value_valid) begin
                grant_cr = 1'b1;
            end
        end
        last_d = grant_cb ? TAG_CB : (grant_cr ? TAG_CR : last_q);
    end

    assign cb_ready = grant_cb;
    assign cr_ready = grant_cr;

    // Stage p0: capture the granted luma value and its tag on the accept edge.
    always_comb begin
        vld_p0_d = grant_cb | grant_cr;
        tag_p0_d = grant_cr ? TAG_CR : TAG_CB;
        y_p0_d   = grant_cr ? cr_y_value : cb_y_value;
    end

    // Stage p1: region select, clamped difference and per-tag constants.
    always_comb begin
        vld_p1_d    = vld_p0_q;
        tag_p1_d    = tag_p0_q;
        region_p1_d = REG_MID;
        diff_p1_d   = 8'd0;
        if (y_p0_q <= K_L) begin
            region_p1_d = REG_LOW;
            diff_p1_d   = clamp_sub(y_p0_q, Y_MIN);
        end else if (y_p0_q >= K_H) begin
            region_p1_d = REG_HIGH;
            diff_p1_d   = clamp_sub(Y_MAX, y_p0_q);
        end
        rev_p1_d = 18'd0;
        off_p1_d = (tag_p0_q == TAG_CR) ? W_CR : W_CB;
        if (region_p1_d == REG_LOW) begin
            rev_p1_d = (tag_p0_q == TAG_CR) ? REV_L_CR : REV_L_CB;
            off_p1_d = (tag_p0_q == TAG_CR) ? WL_CR : WL_CB;
        end else if (region_p1_d == REG_HIGH) begin
            rev_p1_d = (tag_p0_q == TAG_CR) ? REV_H_CR : REV_H_CB;
            off_p1_d = (tag_p0_q == TAG_CR) ? WH_CR : WH_CB;
        end
    end

    // Stage p2: the shared 8x18 multiplier.
    always_comb begin
        vld_p2_d    = vld_p1_q;
        tag_p2_d    = tag_p1_q;
        region_p2_d = region_p1_q;
        off_p2_d    = off_p1_q;
        prod_p2_d   = {18'd0, diff_p1_q} * {8'd0, rev_p1_q};
    end

    // Output stage: offset add with saturation, steered to the tag's result port.
    always_comb begin
        sum_p2 = {10'd0, off_p2_q, 9'd0} + {1'b0, prod_p2_q};
        if (region_p2_q == REG_MID) begin
            res_p2 = {1'b0, off_p2_q, 9'd0};
        end else begin
            res_p2 = sat_width(sum_p2);
        end
        cb_vld_d = vld_p2_q && (tag_p2_q == TAG_CB);
        cr_vld_d = vld_p2_q && (tag_p2_q == TAG_CR);
        cb_res_d = cb_vld_d ? res_p2 : cb_res_q;
        cr_res_d = cr_vld_d ? res_p2 : cr_res_q;
    end

    // Control state and result ports: cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q   <= TAG_CR;
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            cb_vld_q <= 1'b0;
            cr_vld_q <= 1'b0;
            cb_res_q <= 18'h0;
            cr_res_q <= 18'h0;
        end else begin
            last_q   <= last_d;
            vld_p0_q <= vld_p0_d;
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            cb_vld_q <= cb_vld_d;
            cr_vld_q <= cr_vld_d;
            cb_res_q <= cb_res_d;
            cr_res_q <= cr_res_d;
        end
    end

    // Pipeline data: qualified by the stage valids, so no reset needed.
    always_ff @(posedge clk) begin
        tag_p0_q    <= tag_p0_d;
        y_p0_q      <= y_p0_d;
        tag_p1_q    <= tag_p1_d;
        region_p1_q <= region_p1_d;
        diff_p1_q   <= diff_p1_d;
        rev_p1_q    <= rev_p1_d;
        off_p1_q    <= off_p1_d;
        tag_p2_q    <= tag_p2_d;
        region_p2_q <= region_p2_d;
        prod_p2_q   <= prod_p2_d;
        off_p2_q    <= off_p2_d;
    end

    assign width_cb_result       = cb_res_q;
    assign width_cb_result_valid = cb_vld_q;
    assign width_cr_result       = cr_res_q;
    assign width_cr_result_valid = cr_vld_q;

endmodule

// File: tb/tb_skin_width_arbiter.sv
`timescale 1ns/1ps
// Directed bench for skin_width_arbiter: default instance plus one with a
// saturating Cb low-region slope.
module tb_skin_width_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  cb_y, cr_y;
    logic        cb_v, cr_v, cb_rdy, cr_rdy;
    logic [17:0] cb_res, cr_res;
    logic        cb_rv, cr_rv;

    logic [7:0]  s_cb_y, s_cr_y;
    logic        s_cb_v, s_cr_v, s_cb_rdy, s_cr_rdy;
    logic [17:0] s_cb_res, s_cr_res;
    logic        s_cb_rv, s_cr_rv;

    int total = 0;
    int bad   = 0;

    skin_width_arbiter dut (
        .clk(clk), .rst(rst),
        .cb_y_value(cb_y), .cb_y_value_valid(cb_v), .cb_ready(cb_rdy),
        .cr_y_value(cr_y), .cr_y_value_valid(cr_v), .cr_ready(cr_rdy),
        .width_cb_result(cb_res), .width_cb_result_valid(cb_rv),
        .width_cr_result(cr_res), .width_cr_result_valid(cr_rv)
    );

    skin_width_arbiter #(.REV_L_CB(18'h3FFFF)) dut_sat (
        .clk(clk), .rst(rst),
        .cb_y_value(s_cb_y), .cb_y_value_valid(s_cb_v), .cb_ready(s_cb_rdy),
        .cr_y_value(s_cr_y), .cr_y_value_valid(s_cr_v), .cr_ready(s_cr_rdy),
        .width_cb_result(s_cb_res), .width_cb_result_valid(s_cb_rv),
        .width_cr_result(s_cr_res), .width_cr_result_valid(s_cr_rv)
    );

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy_of(input int p);
        case (p)
            0:       return cb_rdy;
            1:       return cr_rdy;
            default: return s_cb_rdy;
        endcase
    endfunction

    function automatic logic vld_of(input int p);
        case (p)
            0:       return cb_rv;
            1:       return cr_rv;
            default: return s_cb_rv;
        endcase
    endfunction

    function automatic logic other_vld_of(input int p);
        case (p)
            0:       return cr_rv;
            1:       return cb_rv;
            default: return s_cr_rv;
        endcase
    endfunction

    function automatic logic [17:0] res_of(input int p);
        case (p)
            0:       return cb_res;
            1:       return cr_res;
            default: return s_cb_res;
        endcase
    endfunction

    // Single request on an idle pipeline; result expected exactly 3 edges after accept.
    task automatic send(input int port, input logic [7:0] y, input logic [17:0] exp, input string name);
        case (port)
            0:       begin cb_y = y;   cb_v = 1'b1;   end
            1:       begin cr_y = y;   cr_v = 1'b1;   end
            default: begin s_cb_y = y; s_cb_v = 1'b1; end
        endcase
        #1;
        chk({name, " ready"}, 18'(rdy_of(port)), 18'd1);
        tick();
        case (port)
            0:       cb_v = 1'b0;
            1:       cr_v = 1'b0;
            default: s_cb_v = 1'b0;
        endcase
        chk({name, " strobe n"}, 18'(vld_of(port)), 18'd0);
        tick();
        chk({name, " strobe n+1"}, 18'(vld_of(port)), 18'd0);
        chk({name, " other n+1"}, 18'(other_vld_of(port)), 18'd0);
        tick();
        chk({name, " strobe n+2"}, 18'(vld_of(port)), 18'd0);
        chk({name, " other n+2"}, 18'(other_vld_of(port)), 18'd0);
        tick();
        chk({name, " strobe n+3"}, 18'(vld_of(port)), 18'd1);
        chk({name, " result"}, res_of(port), exp);
        chk({name, " other n+3"}, 18'(other_vld_of(port)), 18'd0);
        tick();
        chk({name, " strobe n+4"}, 18'(vld_of(port)), 18'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cb_v = 1'b0; cr_v = 1'b0; cb_y = 8'd16; cr_y = 8'd200;
        s_cb_v = 1'b0; s_cr_v = 1'b0; s_cb_y = 8'd0; s_cr_y = 8'd0;
        tick();
        tick();

        // Reset state
        chk("reset cb_res", cb_res, 18'h0);
        chk("reset cr_res", cr_res, 18'h0);
        chk("reset cb_rv", 18'(cb_rv), 18'd0);
        chk("reset cr_rv", 18'(cr_rv), 18'd0);
        chk("reset sat cb_res", s_cb_res, 18'h0);
        cb_v = 1'b1;
        cr_v = 1'b1;
        #1;
        chk("reset cb_ready forced", 18'(cb_rdy), 18'd0);
        chk("reset cr_ready forced", 18'(cr_rdy), 18'd0);
        tick();
        rst = 1'b0;
        #1;

        // Both requesters valid from reset: Cb, Cr, Cb, Cr, Cb, Cr
        for (int k = 1; k <= 10; k++) begin
            if (k <= 6) begin
                chk($sformatf("arb cb_ready k%0d", k), 18'(cb_rdy), 18'(k % 2 == 1));
                chk($sformatf("arb cr_ready k%0d", k), 18'(cr_rdy), 18'(k % 2 == 0));
            end
            tick();
            if (k == 6) begin
                cb_v = 1'b0;
                cr_v = 1'b0;
            end
            chk($sformatf("arb cb_rv k%0d", k), 18'(cb_rv), 18'(k >= 4 && k <= 9 && (k - 4) % 2 == 0));
            chk($sformatf("arb cr_rv k%0d", k), 18'(cr_rv), 18'(k >= 4 && k <= 9 && (k - 4) % 2 == 1));
            if (cb_rv === 1'b1) chk($sformatf("arb cb_res k%0d", k), cb_res, 18'h02E00);
            if (cr_rv === 1'b1) chk($sformatf("arb cr_res k%0d", k), cr_res, 18'h03ECB);
        end

        // Cb low, mid and high regions
        send(0, 8'd16,  18'h02E00, "cb y16");
        send(0, 8'd125, 18'h049AD, "cb y125");
        send(0, 8'd5,   18'h02E00, "cb y5 clamp");
        send(0, 8'd150, 18'h05E00, "cb y150 mid");
        send(0, 8'd188, 18'h05DE9, "cb y188");
        send(0, 8'd235, 18'h01C00, "cb y235");
        // Cr high region
        send(1, 8'd200, 18'h03ECB, "cr y200");
        // Saturation and recovery
        send(2, 8'd125, 18'h3FFFF, "sat cb y125");
        send(2, 8'd16,  18'h02E00, "sat cb y16");

        // Reset mid-stream
        cb_y = 8'd16;
        cb_v = 1'b1;
        #1;
        chk("mid cb_ready", 18'(cb_rdy), 18'd1);
        tick();
        rst = 1'b1;
        cr_y = 8'd200;
        cr_v = 1'b1;
        #1;
        chk("mid rst cb_ready", 18'(cb_rdy), 18'd0);
        chk("mid rst cr_ready", 18'(cr_rdy), 18'd0);
        tick();
        chk("mid rst cb_res", cb_res, 18'h0);
        chk("mid rst cr_res", cr_res, 18'h0);
        chk("mid rst cb_rv", 18'(cb_rv), 18'd0);
        chk("mid rst cr_rv", 18'(cr_rv), 18'd0);
        rst = 1'b0;
        #1;
        chk("post rst cb_ready", 18'(cb_rdy), 18'd1);
        chk("post rst cr_ready", 18'(cr_rdy), 18'd0);
        tick();
        cb_v = 1'b0;
        cr_v = 1'b0;
        chk("mid n+2 cb_rv", 18'(cb_rv), 18'd0);
        tick();
        chk("mid n+3 cb_rv dropped", 18'(cb_rv), 18'd0);
        chk("mid n+3 cr_rv", 18'(cr_rv), 18'd0);
        tick();
        chk("mid n+4 cb_rv", 18'(cb_rv), 18'd0);
        tick();
        chk("post rst cb_rv", 18'(cb_rv), 18'd1);
        chk("post rst cb_res", cb_res, 18'h02E00);
        chk("post rst cr_rv", 18'(cr_rv), 18'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
